// File: rtl/data_memory_lsu_if.sv
// -----------------------------------------------------------------------------
// data_memory_lsu_if
// Memory-stage bus between the core and the data memory / load-store unit.
//
// Signals:
//   memRead      core -> mem  load enable
//   memWrite     core -> mem  store enable
//   funct3       core -> mem  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   read_addr    core -> mem  byte address (ALU result)
//   write_data   core -> mem  right-aligned store data (rs2)
//   memData_out  mem -> core  extended load result
//   busy         mem -> core  memory is clearing or in reset; accesses ignored
//   err          mem -> core  misaligned or illegal access
//
// Modports: master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_memory_lsu_if;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] read_addr;
    logic [31:0] write_data;
    logic [31:0] memData_out;
    logic        busy;
    logic        err;

    modport master (
        output memRead,
        output memWrite,
        output funct3,
        output read_addr,
        output write_data,
        input  memData_out,
        input  busy,
        input  err
    );

    modport slave (
        input  memRead,
        input  memWrite,
        input  funct3,
        input  read_addr,
        input  write_data,
        output memData_out,
        output busy,
        output err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// -----------------------------------------------------------------------------
// data_memory_lsu
// Data memory for the single-cycle RISC-V core. Byte/halfword/word loads and
// stores with sign/zero extension, alignment and illegal-size detection, and a
// sequential post-reset clear engine that zeroes one word per cycle so the
// array has a single write port and can map to block RAM.
//
// Parameters:
//   DEPTH_WORDS     number of 32-bit words (power of two, >= 2)
//   CLEAR_ON_RESET  1 = zero the array word by word after reset, 0 = skip
//   IDX_W           word-index width, derived from DEPTH_WORDS
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   data_memory_lsu_if.slave (memRead, memWrite, funct3, read_addr,
//         write_data in; memData_out, busy, err out)
//
// Loads are combinational so the single-cycle core sees the data in the same
// cycle; stores take effect at the clock edge.
// -----------------------------------------------------------------------------
module data_memory_lsu #(
    parameter int DEPTH_WORDS    = 64,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int IDX_W          = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_lsu_if.slave        bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

    clr_state_t        state_r;
    logic [IDX_W-1:0]  cnt_r;
    logic [31:0]       mem_r [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic              ld_legal_s;
    logic              st_legal_s;
    logic              misal_s;
    logic              err_s;
    logic              busy_s;
    logic              store_en_s;
    logic              clear_we_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       load_val_s;
    logic [31:0]       mem_out_s;

    // Address bits above the word index are deliberately ignored (wrap-around).
    logic              addr_unused_s;
    assign addr_unused_s = &{1'b0, bus.read_addr[31:IDX_W+2]};

    // Select the addressed byte/half from a word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = word[8*lane +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b010:  res_v = word;
            3'b100:  res_v = {24'd0, byte_v};
            3'b101:  res_v = {16'd0, half_v};
            default: res_v = 32'd0;
        endcase
        return res_v;
    endfunction

    // Decode funct3 into legality and alignment checks, and form the error flag.
    always_comb begin
        idx_s      = bus.read_addr[IDX_W+1:2];
        lane_s     = bus.read_addr[1:0];
        ld_legal_s = 1'b0;
        st_legal_s = 1'b0;
        misal_s    = 1'b0;
        case (bus.funct3)
            3'b000: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
                misal_s    = 1'b0;
            end
            3'b001: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
                misal_s    = lane_s[0];
            end
            3'b010: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
                misal_s    = |lane_s;
            end
            3'b100: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b0;
                misal_s    = 1'b0;
            end
            3'b101: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b0;
                misal_s    = lane_s[0];
            end
            default: begin
                ld_legal_s = 1'b0;
                st_legal_s = 1'b0;
                misal_s    = 1'b0;
            end
        endcase
        // Unsigned sizes (100/101) are load-only, so a store using them errors.
        err_s = (bus.memRead  & (~ld_legal_s | misal_s)) |
                (bus.memWrite & (~st_legal_s | misal_s));
    end

    // Busy while clearing or while reset is held; gate stores accordingly.
    always_comb begin
        busy_s     = (state_r == ST_CLEAR) | ~rst;
        store_en_s = bus.memWrite & ~busy_s & ~err_s;
        clear_we_s = rst & (state_r == ST_CLEAR);
    end

    // Replicate store data across lanes and build the byte-enable mask.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'd0;
        case (bus.funct3[1:0])
            2'b00: begin
                wdata_s = {4{bus.write_data[7:0]}};
                be_s    = 4'b0001 << lane_s;
            end
            2'b01: begin
                wdata_s = {2{bus.write_data[15:0]}};
                be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdata_s = bus.write_data;
                be_s    = 4'b1111;
            end
            default: begin
                wdata_s = 32'd0;
                be_s    = 4'b0000;
            end
        endcase
    end

    // Combinational load path; reads pre-write contents when a store is pending.
    always_comb begin
        rd_word_s  = mem_r[idx_s];
        load_val_s = extend_load(rd_word_s, bus.funct3, lane_s);
        if (bus.memRead & ~busy_s & ~err_s) begin
            mem_out_s = load_val_s;
        end else begin
            mem_out_s = 32'd0;
        end
    end

    // Clear sequencer: restart from word 0 on every reset, walk to the last word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and byte-masked stores.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= 32'd0;
        end else if (store_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.memData_out = mem_out_s;
    assign bus.busy        = busy_s;
    assign bus.err         = err_s;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: a byte-array reference model
// predicts load data and error flags for directed and random accesses.
module tb_data_memory_lsu;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_memory_lsu_if bus_a ();
    data_memory_lsu_if bus_b ();

    data_memory_lsu #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    data_memory_lsu #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Reference model: 256 bytes of memory (64 words), byte addresses wrap.
    logic [7:0] ref_b [256];

    function automatic logic ref_err(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        bit ld_ok, st_ok, mis;
        sz    = 1 << f3[1:0];
        ld_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        st_ok = (f3 <= 3'd2);
        mis   = (int'(addr[2:0]) % sz) != 0;
        return (rd && (!ld_ok || mis)) || (wr && (!st_ok || mis));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz, base;
        longint v;
        sz   = 1 << f3[1:0];
        base = int'(addr[7:0]);
        v    = 0;
        for (int i = 0; i < sz && i < 4; i++)
            v = v + (longint'(ref_b[(base + i) % 256]) << (8 * i));
        if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        int sz, base;
        sz   = 1 << f3[1:0];
        base = int'(addr[7:0]);
        for (int i = 0; i < sz; i++)
            ref_b[(base + i) % 256] = data[8*i +: 8];
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
    endtask

    task automatic drive_a(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data);
        bus_a.memRead    = rd;
        bus_a.memWrite   = wr;
        bus_a.funct3     = f3;
        bus_a.read_addr  = addr;
        bus_a.write_data = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        drive_a(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (3) tick();
        checks++;
        if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus_a.busy); end
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b001, 32'h1, 32'h0);
        checks++;
        if (bus_a.err !== 1'b1) begin errors++; $display("FAIL reset_err: got %b expected 1", bus_a.err); end
        drive_a(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rst_a = 1'b1;
        #1;
        for (int e = 1; e <= 64; e++) begin
            if (e == 64) drive_a(1'b0, 1'b1, 3'b010, 32'h000000FC, 32'hCAFEF00D);
            checks++;
            if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL clear_busy edge %0d: got %b expected 1", e, bus_a.busy); end
            tick();
        end
        drive_a(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", bus_a.busy); end
        ref_clear();
        drive_a(1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL clear_lw00: got %h expected 0", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b010, 32'h7C, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL clear_lw7c: got %h expected 0", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b010, 32'hFC, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL dropped_sw: got %h expected 0", bus_a.memData_out); end
    endtask

    task automatic test_byte_half();
        drive_a(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344); tick(); ref_store(3'b010, 32'h10, 32'h11223344);
        drive_a(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA); tick(); ref_store(3'b000, 32'h11, 32'h000000AA);
        drive_a(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF); tick(); ref_store(3'b001, 32'h12, 32'h0000BEEF);
        drive_a(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'hBEEFAA44) begin errors++; $display("FAIL lw_merge: got %h expected beefaa44", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb: got %h expected ffffffaa", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h000000AA) begin errors++; $display("FAIL lbu: got %h expected 000000aa", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh: got %h expected ffffbeef", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0000BEEF) begin errors++; $display("FAIL lhu: got %h expected 0000beef", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h00000044) begin errors++; $display("FAIL lb_pos: got %h expected 00000044", bus_a.memData_out); end
    endtask

    task automatic test_misaligned();
        drive_a(1'b0, 1'b1, 3'b010, 32'h21, 32'hDEADBEEF);
        checks++;
        if (bus_a.err !== 1'b1) begin errors++; $display("FAIL sw_misal_err: got %b expected 1", bus_a.err); end
        tick();
        drive_a(1'b0, 1'b1, 3'b100, 32'h24, 32'h000000FF);
        checks++;
        if (bus_a.err !== 1'b1) begin errors++; $display("FAIL sbu_illegal_err: got %b expected 1", bus_a.err); end
        tick();
        drive_a(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (bus_a.memData_out !== ref_load(3'b010, 32'h20)) begin errors++; $display("FAIL sw_misal_nowrite: got %h expected %h", bus_a.memData_out, ref_load(3'b010, 32'h20)); end
        drive_a(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL sbu_nowrite: got %h expected 0", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b001, 32'h23, 32'h0);
        checks++;
        if (bus_a.err !== 1'b1 || bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL lh_misal: got err=%b out=%h expected err=1 out=0", bus_a.err, bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        checks++;
        if (bus_a.err !== 1'b1 || bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL f3_011: got err=%b out=%h expected err=1 out=0", bus_a.err, bus_a.memData_out); end
        drive_a(1'b0, 1'b0, 3'b011, 32'h23, 32'h0);
        checks++;
        if (bus_a.err !== 1'b0) begin errors++; $display("FAIL idle_err: got %b expected 0", bus_a.err); end
    endtask

    task automatic test_wrap();
        drive_a(1'b0, 1'b1, 3'b010, 32'h104, 32'h5A5A5A5A); tick(); ref_store(3'b010, 32'h104, 32'h5A5A5A5A);
        drive_a(1'b1, 1'b0, 3'b010, 32'h004, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h5A5A5A5A) begin errors++; $display("FAIL wrap: got %h expected 5a5a5a5a", bus_a.memData_out); end
    endtask

    task automatic test_random();
        logic        rd, wr, e_err;
        logic [2:0]  f3;
        logic [31:0] addr, data, e_out;
        for (int n = 0; n < 400; n++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            data = $urandom;
            drive_a(rd, wr, f3, addr, data);
            e_err = ref_err(rd, wr, f3, addr);
            e_out = (rd && !e_err) ? ref_load(f3, addr) : 32'h0;
            checks++;
            if (bus_a.err !== e_err) begin errors++; $display("FAIL rand_err #%0d f3=%0d a=%h: got %b expected %b", n, f3, addr, bus_a.err, e_err); end
            checks++;
            if (bus_a.memData_out !== e_out) begin errors++; $display("FAIL rand_out #%0d f3=%0d a=%h: got %h expected %h", n, f3, addr, bus_a.memData_out, e_out); end
            tick();
            if (wr && !e_err) ref_store(f3, addr, data);
        end
        drive_a(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic test_mid_clear();
        drive_a(1'b0, 1'b1, 3'b010, 32'h10, 32'h12345678); tick();
        drive_a(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h12345678) begin errors++; $display("FAIL pre_clear_sw: got %h expected 12345678", bus_a.memData_out); end
        drive_a(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rst_a = 1'b0; tick();
        rst_a = 1'b1; #1;
        for (int e = 1; e <= 10; e++) begin
            checks++;
            if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL mid_busy1 edge %0d: got %b expected 1", e, bus_a.busy); end
            tick();
        end
        rst_a = 1'b0; tick();
        rst_a = 1'b1; #1;
        for (int e = 1; e <= 64; e++) begin
            checks++;
            if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL mid_busy2 edge %0d: got %b expected 1", e, bus_a.busy); end
            tick();
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", bus_a.busy); end
        ref_clear();
        drive_a(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL mid_cleared: got %h expected 0", bus_a.memData_out); end
        drive_a(1'b1, 1'b0, 3'b010, 32'hF8, 32'h0);
        checks++;
        if (bus_a.memData_out !== 32'h0) begin errors++; $display("FAIL mid_cleared_top: got %h expected 0", bus_a.memData_out); end
    endtask

    task automatic test_no_clear();
        rst_b = 1'b0; tick();
        checks++;
        if (bus_b.busy !== 1'b1) begin errors++; $display("FAIL nc_reset_busy: got %b expected 1", bus_b.busy); end
        bus_b.memRead = 1'b0; bus_b.memWrite = 1'b1; bus_b.funct3 = 3'b010;
        bus_b.read_addr = 32'h0; bus_b.write_data = 32'h1;
        rst_b = 1'b1; #1;
        checks++;
        if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL nc_busy: got %b expected 0", bus_b.busy); end
        tick();
        bus_b.memRead = 1'b1; bus_b.memWrite = 1'b0; #1;
        checks++;
        if (bus_b.memData_out !== 32'h1) begin errors++; $display("FAIL nc_first_sw: got %h expected 1", bus_b.memData_out); end
        bus_b.memRead = 1'b0; #1;
    endtask

    initial begin
        bus_a.memRead = 1'b0; bus_a.memWrite = 1'b0; bus_a.funct3 = 3'b010;
        bus_a.read_addr = 32'h0; bus_a.write_data = 32'h0;
        bus_b.memRead = 1'b0; bus_b.memWrite = 1'b0; bus_b.funct3 = 3'b010;
        bus_b.read_addr = 32'h0; bus_b.write_data = 32'h0;
        ref_clear();
        tick();
        test_reset();
        test_byte_half();
        test_misaligned();
        test_wrap();
        test_random();
        test_mid_clear();
        test_no_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
